// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of N_SRC first-word-fall-through sources into one
// registered 32-bit word stream with burst grants and optional source tags.
module fifo_stream_arbiter #(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 16,
    parameter bit TAG_EN    = 1'b0,
    parameter int ID_W      = 3
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [N_SRC-1:0]     SRC_EMPTY,
    input  logic [32*N_SRC-1:0]  SRC_DATA,
    output logic [N_SRC-1:0]     SRC_READ,
    output logic                 ARB_WRITE_OUT,
    output logic [31:0]          ARB_DATA_OUT,
    input  logic                 ARB_READY_OUT,
    output logic [ID_W-1:0]      GRANT_ID,
    output logic [31:0]          WORD_CNT
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [BW-1:0]   burst_cnt;

    logic            pop;
    logic            can_load;
    logic            load;
    logic            last_beat;

    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic [ID_W-1:0] next_id;
    logic            any_req;

    logic            g_empty;
    logic [31:0]     g_data;
    logic [31:0]     load_data;

    assign pop      = ARB_WRITE_OUT & ARB_READY_OUT;
    assign can_load = !ARB_WRITE_OUT | pop;

    // Lowest requester above the last grant wins, else lowest at/below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (!SRC_EMPTY[i]) begin
                if (ID_W'(i) > GRANT_ID) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = ID_W'(i);
                end
            end
        end
    end

    assign any_req = hi_found | lo_found;
    assign next_id = hi_found ? hi_id : lo_id;

    always_comb begin
        g_empty = 1'b1;
        g_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (GRANT_ID == ID_W'(i)) begin
                g_empty = SRC_EMPTY[i];
                g_data  = SRC_DATA[32*i +: 32];
            end
        end
    end

    generate
        if (TAG_EN) begin : g_tag
            assign load_data = {4'(GRANT_ID), g_data[27:0]};
        end else begin : g_notag
            assign load_data = g_data;
        end
    endgenerate

    assign load      = (state == BURST) & !g_empty & can_load & !BUS_RST;
    assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));

    always_comb begin
        SRC_READ = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (GRANT_ID == ID_W'(i)) begin
                SRC_READ[i] = load;
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state         <= IDLE;
            burst_cnt     <= '0;
            ARB_WRITE_OUT <= 1'b0;
            ARB_DATA_OUT  <= '0;
            GRANT_ID      <= ID_W'(N_SRC - 1);
            WORD_CNT      <= '0;
        end else begin
            if (pop) begin
                WORD_CNT <= WORD_CNT + 32'd1;
            end

            if (load) begin
                ARB_WRITE_OUT <= 1'b1;
                ARB_DATA_OUT  <= load_data;
            end else if (pop) begin
                ARB_WRITE_OUT <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        GRANT_ID  <= next_id;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (load) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end else if (g_empty && can_load) begin
                        // A stalled output keeps the grant even if the source drains.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Self-checking bench for fifo_stream_arbiter: source models, an output
// scoreboard, a burst-order table and a tag vector table.
module tb_fifo_stream_arbiter;

    localparam int NS = 4;
    localparam int MB = 16;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_empty;
    logic [32*NS-1:0]  src_data;
    logic [NS-1:0]     src_read;
    logic              arb_write;
    logic [31:0]       arb_data;
    logic              arb_ready;
    logic [2:0]        grant_id;
    logic [31:0]       word_cnt;

    logic [NS-1:0]     t_empty;
    logic [32*NS-1:0]  t_data;
    logic [NS-1:0]     t_read;
    logic              t_write;
    logic [31:0]       t_out;
    logic              t_ready;
    logic [2:0]        t_grant;
    logic [31:0]       t_cnt;

    always #5 clk = ~clk;

    fifo_stream_arbiter #(
        .N_SRC(NS), .MAX_BURST(MB), .TAG_EN(1'b0), .ID_W(3)
    ) dut (
        .BUS_CLK(clk), .BUS_RST(rst),
        .SRC_EMPTY(src_empty), .SRC_DATA(src_data), .SRC_READ(src_read),
        .ARB_WRITE_OUT(arb_write), .ARB_DATA_OUT(arb_data),
        .ARB_READY_OUT(arb_ready), .GRANT_ID(grant_id), .WORD_CNT(word_cnt)
    );

    fifo_stream_arbiter #(
        .N_SRC(NS), .MAX_BURST(MB), .TAG_EN(1'b1), .ID_W(3)
    ) dut_tag (
        .BUS_CLK(clk), .BUS_RST(rst),
        .SRC_EMPTY(t_empty), .SRC_DATA(t_data), .SRC_READ(t_read),
        .ARB_WRITE_OUT(t_write), .ARB_DATA_OUT(t_out),
        .ARB_READY_OUT(t_ready), .GRANT_ID(t_grant), .WORD_CNT(t_cnt)
    );

    typedef struct {
        int src;
        int len;
    } burst_t;

    typedef struct {
        int          src;
        logic [31:0] din;
        logic [31:0] dout;
    } tag_vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [NS][DEPTH];
    int          head [NS];
    int          tail [NS];
    logic [31:0] exp_q [$];

    int          cyc = 0;
    logic        ready_q = 1'b0;
    logic [NS-1:0] cap_rd = '0;
    logic        cap_pop = 1'b0;
    logic [31:0] cap_data = '0;
    int          cap_cyc = 0;
    logic        prev_any_rd = 1'b0;
    int          last_g = -1;

    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int rd_total = 0;
    int bad_onehot = 0;
    int bad_empty_rd = 0;
    int bad_rst_rd = 0;

    int     nb = 0;
    burst_t got_b [32];
    burst_t exp_b [12];
    tag_vec_t tv [4];

    int n;
    int fill_cyc;
    int stall_bad_v;
    int stall_bad_d;
    int stall_bad_r;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        prev_any_rd = 1'b0;
    endtask

    task automatic push_word(input int s, input logic [31:0] w);
        mem[s][tail[s]] = w;
        tail[s]++;
    endtask

    // One clock: apply last cycle's transfers, drive inputs, sample outputs.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                if (cap_rd[i] && head[i] < tail[i]) begin
                    exp_q.push_back(mem[i][head[i]]);
                    head[i]++;
                    if (!prev_any_rd || i != last_g) begin
                        got_b[nb].src = i;
                        got_b[nb].len = 0;
                        if (nb < 31) nb++;
                    end
                    got_b[nb-1].len++;
                    last_g = i;
                end
            end
            prev_any_rd = |cap_rd;
            if (cap_pop) begin
                pops++;
                if (first_pop < 0) first_pop = cap_cyc;
                last_pop = cap_cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra: got 0x%08h expected no word", cap_data);
                end else begin
                    check("sb_data", cap_data, exp_q.pop_front());
                end
            end
        end
        #1;
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (head[i] >= tail[i]);
            src_data[32*i +: 32] = (head[i] < tail[i]) ? mem[i][head[i]] : 32'h0;
        end
        arb_ready = ready_q;
        #1;
        cap_rd   = src_read;
        cap_pop  = arb_write & arb_ready;
        cap_data = arb_data;
        cap_cyc  = cyc;
        if ($countones(src_read) > 1) bad_onehot++;
        if (|src_read) rd_total++;
        if (rst && |src_read) bad_rst_rd++;
        for (int i = 0; i < NS; i++) begin
            if (src_read[i] && head[i] >= tail[i]) bad_empty_rd++;
        end
    endtask

    task automatic tag_vec(input int s, input logic [31:0] d,
                           input logic [31:0] e, input logic [31:0] cnt0);
        int k;
        t_data = '0;
        t_data[32*s +: 32] = d;
        t_empty = '1;
        t_empty[s] = 1'b0;
        t_ready = 1'b0;
        k = 0;
        while (!t_write && k < 20) begin
            @(posedge clk);
            #1;
            if (t_write) t_empty[s] = 1'b1;
            k++;
        end
        check("tag_valid", {31'b0, t_write}, 32'd1);
        check("tag_data", t_out, e);
        t_ready = 1'b1;
        @(posedge clk);
        #1;
        t_ready = 1'b0;
        check("tag_cnt", t_cnt, cnt0 + 32'd1);
        check("tag_drained", {31'b0, t_write}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            exp_b[i].src = i % NS;
            exp_b[i].len = (i < 8) ? MB : 8;
        end
        tv[0] = '{src: 2, din: 32'hFFFF_FFFF, dout: 32'h2FFF_FFFF};
        tv[1] = '{src: 0, din: 32'h1234_5678, dout: 32'h0234_5678};
        tv[2] = '{src: 3, din: 32'h0000_0000, dout: 32'h3000_0000};
        tv[3] = '{src: 1, din: 32'hA5A5_A5A5, dout: 32'h15A5_A5A5};

        rst = 1'b1;
        arb_ready = 1'b0;
        src_empty = '1;
        src_data = '0;
        t_empty = '1;
        t_data = '0;
        t_ready = 1'b0;
        clear_model();
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_write", {31'b0, arb_write}, 32'd0);
        check("rst_data", arb_data, 32'd0);
        check("rst_read", {28'b0, src_read}, 32'd0);
        check("rst_grant", {29'b0, grant_id}, 32'd3);
        check("rst_cnt", word_cnt, 32'd0);

        // Single source, back-to-back
        for (int k = 1; k <= 5; k++) push_word(0, 32'(k));
        ready_q = 1'b1;
        fill_cyc = cyc + 1;
        pops = 0;
        first_pop = -1;
        repeat (10) step();
        check("single_pops", 32'(pops), 32'd5);
        check("single_latency", 32'(first_pop - fill_cyc), 32'd2);
        check("single_b2b", 32'(last_pop - first_pop), 32'd4);
        check("single_cnt", word_cnt, 32'd5);
        check("single_idle", {31'b0, arb_write}, 32'd0);
        check("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stray pop while nothing is valid
        rd_total = 0;
        ready_q = 1'b1; step();
        ready_q = 1'b0; step();
        ready_q = 1'b1; step();
        check("stray_cnt", word_cnt, 32'd5);
        check("stray_reads", 32'(rd_total), 32'd0);

        // Backpressure
        ready_q = 1'b0;
        pops = 0;
        for (int k = 0; k < 6; k++) push_word(1, 32'h0100_0000 + 32'(k));
        for (n = 0; n < 20 && !arb_write; n++) step();
        check("bp_valid", {31'b0, arb_write}, 32'd1);
        check("bp_grant", {29'b0, grant_id}, 32'd1);
        stall_bad_v = 0;
        stall_bad_d = 0;
        stall_bad_r = 0;
        repeat (10) begin
            step();
            if (!arb_write) stall_bad_v++;
            if (arb_data !== 32'h0100_0000) stall_bad_d++;
            if (|src_read) stall_bad_r++;
        end
        check("bp_hold_valid", 32'(stall_bad_v), 32'd0);
        check("bp_hold_data", 32'(stall_bad_d), 32'd0);
        check("bp_no_read", 32'(stall_bad_r), 32'd0);
        ready_q = 1'b1;
        repeat (15) step();
        check("bp_pops", 32'(pops), 32'd6);
        check("bp_cnt", word_cnt, 32'd11);
        check("bp_drained", 32'(head[1]), 32'd6);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-burst with a held word
        ready_q = 1'b0;
        for (int k = 0; k < 4; k++) push_word(1, 32'h0110_0000 + 32'(k));
        for (n = 0; n < 20 && !arb_write; n++) step();
        check("mid_valid", {31'b0, arb_write}, 32'd1);
        check("mid_grant", {29'b0, grant_id}, 32'd1);
        rst = 1'b1;
        clear_model();
        step();
        check("mid_rst_write", {31'b0, arb_write}, 32'd0);
        check("mid_rst_cnt", word_cnt, 32'd0);
        check("mid_rst_grant", {29'b0, grant_id}, 32'd3);
        rst = 1'b0;
        step();

        // Fairness over four full sources
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 40; k++) push_word(s, 32'((s << 24) | k));
        end
        nb = 0;
        pops = 0;
        ready_q = 1'b1;
        for (n = 0; n < 400 && pops < 160; n++) step();
        repeat (3) step();
        check("fair_pops", 32'(pops), 32'd160);
        check("fair_cnt", word_cnt, 32'd160);
        check("fair_nbursts", 32'(nb), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("fair_src%0d", i), 32'(got_b[i].src), 32'(exp_b[i].src));
            check($sformatf("fair_len%0d", i), 32'(got_b[i].len), 32'(exp_b[i].len));
        end
        check("fair_idle", {31'b0, arb_write}, 32'd0);

        // Source tagging
        for (int i = 0; i < 4; i++) begin
            tag_vec(tv[i].src, tv[i].din, tv[i].dout, 32'(i));
        end

        check("onehot_read", 32'(bad_onehot), 32'd0);
        check("read_empty_src", 32'(bad_empty_rd), 32'd0);
        check("read_in_reset", 32'(bad_rst_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
